message_writer: RTL and testbench

Writer side of the 16-entry, 4-bit message memory that the display character driver reads. It takes debounced, synchronized push-button levels and a 4-bit switch value. It issues single-cycle write strobes into the message memory, advancing a wrapping write pointer on each write. It also performs a bulk clear of the whole memory and reports fill status, so the display path knows when a complete message is present.

---
 rtl/message_writer.sv | 129 ++++++++++++
 tb/tb_message_writer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/message_writer.sv
// Write side of the message memory: turns button edges into single-cycle
// write strobes, runs a full-memory clear, and tracks how full the message is.
module message_writer #(
   parameter int              DEPTH      = 16,
   parameter int              AW         = 4,
   parameter int              DW         = 4,
   parameter logic [DW-1:0]   CLEAR_CHAR = '0
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          btn_write,
   input  logic          btn_clear,
   input  logic [DW-1:0] data_in,
   output logic          wr_en,
   output logic [AW-1:0] wr_addr,
   output logic [DW-1:0] wr_data,
   output logic [AW-1:0] wr_ptr,
   output logic          busy,
   output logic          msg_full,
   output logic [1:0]    state_dbg
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WRITE = 2'd1,
      S_CLEAR = 2'd2
   } state_t;

   localparam logic [AW:0]   FILL_MAX  = (AW+1)'(DEPTH);
   localparam logic [AW:0]   FILL_LAST = (AW+1)'(DEPTH - 1);
   localparam logic [AW-1:0] CLR_LAST  = AW'(DEPTH - 1);

   state_t        state_q, state_d;
   logic          btn_w_q, btn_c_q;
   logic [DW-1:0] data_q, data_d;
   logic [AW-1:0] ptr_q, ptr_d;
   logic [AW:0]   fill_q, fill_d;
   logic          full_q, full_d;
   logic [AW-1:0] clr_q, clr_d;
   logic [AW-1:0] addr_hold_q, addr_hold_d;
   logic [DW-1:0] data_hold_q, data_hold_d;
   logic          edge_w, edge_c;

   assign edge_w    = btn_write & ~btn_w_q;
   assign edge_c    = btn_clear & ~btn_c_q;
   assign wr_ptr    = ptr_q;
   assign busy      = (state_q == S_CLEAR);
   assign msg_full  = full_q;
   assign state_dbg = state_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         btn_w_q     <= 1'b1;
         btn_c_q     <= 1'b1;
         data_q      <= '0;
         ptr_q       <= '0;
         fill_q      <= '0;
         full_q      <= 1'b0;
         clr_q       <= '0;
         addr_hold_q <= '0;
         data_hold_q <= '0;
      end else begin
         state_q     <= state_d;
         btn_w_q     <= btn_write;
         btn_c_q     <= btn_clear;
         data_q      <= data_d;
         ptr_q       <= ptr_d;
         fill_q      <= fill_d;
         full_q      <= full_d;
         clr_q       <= clr_d;
         addr_hold_q <= addr_hold_d;
         data_hold_q <= data_hold_d;
      end
   end

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      ptr_d   = ptr_q;
      fill_d  = fill_q;
      full_d  = full_q;
      clr_d   = clr_q;
      wr_en   = 1'b0;
      wr_addr = addr_hold_q;
      wr_data = data_hold_q;

      case (state_q)
         S_IDLE: begin
            // A clear edge wins; a simultaneous write edge is dropped.
            if (edge_c) begin
               state_d = S_CLEAR;
               clr_d   = '0;
            end else if (edge_w) begin
               state_d = S_WRITE;
               data_d  = data_in;
            end
         end
         S_WRITE: begin
            wr_en   = 1'b1;
            wr_addr = ptr_q;
            wr_data = data_q;
            ptr_d   = ptr_q + 1'b1;
            if (fill_q != FILL_MAX) fill_d = fill_q + 1'b1;
            full_d  = full_q | (fill_q == FILL_LAST);
            clr_d   = '0;
            // A clear edge arriving during the write is honoured afterwards.
            state_d = edge_c ? S_CLEAR : S_IDLE;
         end
         S_CLEAR: begin
            wr_en   = 1'b1;
            wr_addr = clr_q;
            wr_data = CLEAR_CHAR;
            clr_d   = clr_q + 1'b1;
            if (clr_q == CLR_LAST) begin
               state_d = S_IDLE;
               ptr_d   = '0;
               fill_d  = '0;
               full_d  = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase

      addr_hold_d = wr_addr;
      data_hold_d = wr_data;
   end

endmodule

// File: tb/tb_message_writer.sv
// Bench for message_writer: directed scenarios plus random button activity,
// every cycle compared against a behavioural model of the writer.
module tb_message_writer;

   localparam int DEPTH = 16;

   logic       clk;
   logic       reset;
   logic       btn_write;
   logic       btn_clear;
   logic [3:0] data_in;
   logic       wr_en;
   logic [3:0] wr_addr;
   logic [3:0] wr_data;
   logic [3:0] wr_ptr;
   logic       busy;
   logic       msg_full;
   logic [1:0] state_dbg;

   int checks = 0;
   int errors = 0;

   // behavioural model state
   int m_prev_w, m_prev_c;
   int m_ptr, m_fill, m_full;
   int m_clear_left;
   int m_pend, m_pend_addr, m_pend_data;
   int m_last_addr, m_last_data;

   message_writer dut (
      .clk       (clk),
      .reset     (reset),
      .btn_write (btn_write),
      .btn_clear (btn_clear),
      .data_in   (data_in),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wr_ptr    (wr_ptr),
      .busy      (busy),
      .msg_full  (msg_full),
      .state_dbg (state_dbg)
   );

   // clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got=%0h exp=%0h", tag, $time, got, exp);
      end
   endtask

   task automatic model_reset();
      m_prev_w = 1; m_prev_c = 1;
      m_ptr = 0; m_fill = 0; m_full = 0;
      m_clear_left = 0;
      m_pend = 0; m_pend_addr = 0; m_pend_data = 0;
      m_last_addr = 0; m_last_data = 0;
   endtask

   // Advance the model by one rising edge using the inputs now driven.
   task automatic model_step();
      int ew, ec;
      ew = (btn_write && !m_prev_w) ? 1 : 0;
      ec = (btn_clear && !m_prev_c) ? 1 : 0;
      m_prev_w = btn_write;
      m_prev_c = btn_clear;
      if (m_clear_left > 0) begin
         m_last_addr = DEPTH - m_clear_left;
         m_last_data = 0;
         m_clear_left--;
         if (m_clear_left == 0) begin
            m_ptr = 0; m_fill = 0; m_full = 0;
         end
      end else if (m_pend) begin
         m_last_addr = m_pend_addr;
         m_last_data = m_pend_data;
         m_ptr = (m_ptr + 1) % DEPTH;
         if (m_fill < DEPTH) m_fill++;
         m_full = (m_fill == DEPTH) ? 1 : 0;
         m_pend = 0;
         if (ec) m_clear_left = DEPTH;
      end else if (ec) begin
         m_clear_left = DEPTH;
      end else if (ew) begin
         m_pend = 1;
         m_pend_addr = m_ptr;
         m_pend_data = data_in;
      end
   endtask

   task automatic check_outputs();
      int e_en, e_addr, e_data;
      if (m_pend) begin
         e_en = 1; e_addr = m_pend_addr; e_data = m_pend_data;
      end else if (m_clear_left > 0) begin
         e_en = 1; e_addr = DEPTH - m_clear_left; e_data = 0;
      end else begin
         e_en = 0; e_addr = m_last_addr; e_data = m_last_data;
      end
      check_eq("wr_en",    32'(wr_en),    32'(e_en));
      check_eq("wr_addr",  32'(wr_addr),  32'(e_addr));
      check_eq("wr_data",  32'(wr_data),  32'(e_data));
      check_eq("wr_ptr",   32'(wr_ptr),   32'(m_ptr));
      check_eq("busy",     32'(busy),     32'(m_clear_left > 0));
      check_eq("msg_full", 32'(msg_full), 32'(m_full));
   endtask

   // driver tasks
   task automatic step(input logic bw, input logic bc, input logic [3:0] d);
      @(negedge clk);
      check_outputs();
      btn_write = bw;
      btn_clear = bc;
      data_in   = d;
      model_step();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'($urandom_range(0, 15)));
   endtask

   task automatic press_write(input logic [3:0] d);
      step(1'b1, 1'b0, d);
      step(1'b0, 1'b0, d);
      step(1'b0, 1'b0, d);
   endtask

   task automatic do_reset(input logic bw);
      @(negedge clk);
      reset     = 1'b0;
      btn_write = bw;
      btn_clear = 1'b0;
      model_reset();
      repeat (3) begin
         @(negedge clk);
         check_outputs();
      end
      reset = 1'b1;
      model_step();
   endtask

   task automatic async_reset_zero_check();
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check_eq("rst_wr_en",    32'(wr_en),    32'd0);
      check_eq("rst_wr_addr",  32'(wr_addr),  32'd0);
      check_eq("rst_wr_data",  32'(wr_data),  32'd0);
      check_eq("rst_wr_ptr",   32'(wr_ptr),   32'd0);
      check_eq("rst_busy",     32'(busy),     32'd0);
      check_eq("rst_msg_full", 32'(msg_full), 32'd0);
      model_reset();
      btn_write = 1'b0;
      btn_clear = 1'b0;
      @(negedge clk);
      check_outputs();
      reset = 1'b1;
      model_step();
   endtask

   initial begin
      reset     = 1'b0;
      btn_write = 1'b0;
      btn_clear = 1'b0;
      data_in   = 4'h0;
      model_reset();

      // first write after reset
      do_reset(1'b0);
      idle(2);
      press_write(4'hA);
      check_eq("first_ptr",  32'(wr_ptr),   32'd1);
      check_eq("first_full", 32'(msg_full), 32'd0);

      // fill all entries, then wrap once
      do_reset(1'b0);
      idle(2);
      for (int i = 0; i < DEPTH; i++) press_write(4'(i));
      check_eq("fill_ptr",  32'(wr_ptr),   32'd0);
      check_eq("fill_full", 32'(msg_full), 32'd1);
      press_write(4'h7);
      check_eq("wrap_ptr",  32'(wr_ptr),   32'd1);
      check_eq("wrap_full", 32'(msg_full), 32'd1);

      // clear with a write press landing mid-clear
      step(1'b0, 1'b1, 4'h0);
      step(1'b0, 1'b0, 4'h0);
      step(1'b0, 1'b0, 4'h0);
      step(1'b1, 1'b0, 4'h9);
      step(1'b0, 1'b0, 4'h9);
      idle(16);
      check_eq("clr_ptr",  32'(wr_ptr),   32'd0);
      check_eq("clr_full", 32'(msg_full), 32'd0);
      check_eq("clr_busy", 32'(busy),     32'd0);

      // simultaneous write and clear edges
      press_write(4'h3);
      step(1'b1, 1'b1, 4'hC);
      step(1'b0, 1'b0, 4'hC);
      idle(18);
      press_write(4'h5);
      check_eq("simul_ptr", 32'(wr_ptr), 32'd1);

      // write button held across reset release
      do_reset(1'b1);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 4'hE);
      check_eq("held_ptr", 32'(wr_ptr), 32'd0);
      step(1'b0, 1'b0, 4'hE);
      press_write(4'hE);
      check_eq("repress_ptr", 32'(wr_ptr), 32'd1);

      // reset mid-clear
      press_write(4'h2);
      step(1'b0, 1'b1, 4'h0);
      step(1'b0, 1'b0, 4'h0);
      idle(5);
      async_reset_zero_check();
      idle(3);

      // random button activity
      for (int i = 0; i < 3000; i++) begin
         logic bw, bc;
         bw = btn_write;
         bc = btn_clear;
         if ($urandom_range(0, 2) == 0) bw = ~bw;
         if ($urandom_range(0, 39) == 0) bc = ~bc;
         step(bw, bc, 4'($urandom_range(0, 15)));
         if ($urandom_range(0, 999) == 0) do_reset(1'($urandom_range(0, 1)));
      end
      idle(20);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
